rtype_instr_encoder: RTL and testbench
======================================

Name: rtype_instr_encoder

Overview:
- Encoder counterpart of the R-type ALU decoder. It takes symbolic ALU operation requests (op select, rd, rs1, rs2) and packs each into a 32-bit RV32 R-type instruction word.
- Encoded words are buffered in a small FIFO and issued to the ALU/decode path through a valid/ready handshake.
- Serves as the instruction source for ALU bring-up and as the issue stage of the future fetch path.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
CNT_W, 16, width of the issued-instruction counter

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request present
in_ready  out  1  encoder can accept a request this cycle
in_op  in  4  operation select (see Behaviour)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
out_valid  out  1  FIFO head holds a valid instruction
out_ready  in  1  downstream accepts the head
out_code  out  32  encoded instruction word at FIFO head
illegal_op  out  1  sticky flag: an illegal op select was seen
issued_cnt  out  CNT_W  count of instructions popped from the FIFO
clr_err  in  1  synchronous clear of illegal_op

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, in_ready=1, out_valid=0, out_code=0, illegal_op=0, issued_cnt=0. Reset mid-operation discards all buffered words.
- Field packing: {funct7, rs2, rs1, funct3, rd, 7'b0110011}, with rs2 in [24:20], rs1 in [19:15], funct3 in [14:12], rd in [11:7].
- in_op encoding, as op: funct7/funct3:
  - 0 ADD: 0000000/000
  - 1 SUB: 0100000/000
  - 2 MUL: 0000001/000
  - 3 AND: 0000000/111
  - 4 OR: 0000000/110
  - 5 XOR: 0000000/100
  - 6 SLT: 0000000/010
  - 7 SLTU: 0000000/011
  - 8 SRL: 0000000/101
  - 9 SLL: 0000000/001
  - 10..15 are illegal.
- Input handshake:
  - Push occurs when in_valid & in_ready.
  - in_ready = (count < DEPTH), registered-count based, with no full-bypass. When full, a same-cycle pop does not enable a push.
- Output handshake:
  - out_valid = (count != 0).
  - out_code is the head entry, driven from registered FIFO storage. It is 0 when empty.
  - Pop occurs when out_valid & out_ready.
  - out_code is stable while out_valid & ~out_ready.
- Latency: a word pushed at edge N is visible on out_code/out_valid after edge N when the FIFO was empty, i.e. 1 cycle.
- Simultaneous push and pop (not full, not empty): count unchanged. Head advances and new tail is written.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits.
- issued_cnt increments by 1 on every pop and wraps 2^CNT_W-1 -> 0.
- illegal_op:
  - Set on any accepted push with in_op >= 10.
  - Cleared by clr_err. If set and clear occur in the same cycle, set wins.
- Pop on empty, or push when full, are ignored; they cannot occur via the handshake.

Optional Feature:
- Macro RTYPE_ILLEGAL_DROP_EN.
- Defined: an accepted illegal request is consumed, sets illegal_op, and is NOT written to the FIFO (count unchanged).
- Undefined: an illegal request is written as the canonical NOP 32'h00000033 (ADD x0,x0,x0) and sets illegal_op.

Test Plan:
- Reset then push op=0, rd=0, rs1=2, rs2=4 with out_ready=1 -> out_code=32'h00410033 one cycle later, issued_cnt=1.
- Push ops 1,2,3,4 with rd=0, rs1=2, rs2=4 -> codes 32'h40410033, 32'h02410033, 32'h00417033, 32'h00416033 in order.
- Hold out_ready=0 and push 5 requests -> in_ready drops after 4th; 5th held. Out stream preserves order, code stable while stalled. Then out_ready=1 for one cycle with in_valid=1 while full -> no push that cycle.
- Continuous push/pop at full rate with 12 requests -> count stays 1, one word per cycle, pointers wrap cleanly, issued_cnt=12.
- Push op=12 -> illegal_op=1. FIFO gets 32'h00000033 (macro off) or count unchanged (macro on). clr_err coincident with a new illegal push -> illegal_op stays 1.
- Assert rst_n low mid-stream with 3 words buffered -> out_valid=0, in_ready=1, illegal_op=0, issued_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rtype_instr_encoder.sv
// ============================================================================
// rtype_instr_encoder: packs symbolic ALU requests into RV32 R-type words and
// buffers them in a DEPTH-entry FIFO with valid/ready on both sides.
// Optional macro RTYPE_ILLEGAL_DROP_EN: illegal requests are dropped, not NOPed.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rtype_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_code,
  output logic             illegal_op,
  output logic [CNT_W-1:0] issued_cnt,
  input  logic             clr_err
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [6:0]      OPCODE   = 7'b0110011;
  localparam logic [31:0]     NOP_CODE = 32'h0000_0033;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic       push;
  logic       pop;
  logic       write_en;
  logic       legal;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [31:0] enc_code;

  always_comb begin
    legal  = 1'b1;
    funct7 = 7'b0000000;
    funct3 = 3'b000;
    case (in_op)
      4'd0:    funct3 = 3'b000;
      4'd1:    funct7 = 7'b0100000;
      4'd2:    funct7 = 7'b0000001;
      4'd3:    funct3 = 3'b111;
      4'd4:    funct3 = 3'b110;
      4'd5:    funct3 = 3'b100;
      4'd6:    funct3 = 3'b010;
      4'd7:    funct3 = 3'b011;
      4'd8:    funct3 = 3'b101;
      4'd9:    funct3 = 3'b001;
      default: legal  = 1'b0;
    endcase
  end

  assign enc_code = legal ? {funct7, in_rs2, in_rs1, funct3, in_rd, OPCODE} : NOP_CODE;

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef RTYPE_ILLEGAL_DROP_EN
  assign write_en = push & legal;
`else
  assign write_en = push;
`endif

  // Storage needs no reset: out_code is masked by count, which is reset.
  always_ff @(posedge clk) begin
    if (write_en) mem[wr_ptr] <= enc_code;
  end

  assign out_code = out_valid ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      issued_cnt <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      case ({write_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !legal) illegal_op <= 1'b1;
      else if (clr_err)   illegal_op <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtype_instr_encoder.sv
// ============================================================================
// tb_rtype_instr_encoder: directed plus randomized checks against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rtype_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_op = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_code;
  logic             illegal_op;
  logic [CNT_W-1:0] issued_cnt;
  logic             clr_err = 1'b0;

  rtype_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .illegal_op(illegal_op), .issued_cnt(issued_cnt), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]      m_q [$];
  logic             m_ill = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  int unsigned f7_tab [10] = '{7'h00, 7'h20, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  int unsigned f3_tab [10] = '{0, 0, 0, 7, 6, 4, 2, 3, 5, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_code(input int op, input int rd, input int rs1, input int rs2);
    if (op >= 10) return 32'h33;
    return 32'(f7_tab[op] * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
               + f3_tab[op] * (1 << 12) + rd * (1 << 7) + 51);
  endfunction

  // One clock cycle: check DUT against the model, drive inputs, advance the model.
  task automatic step(input logic v, input int op, input int rd, input int rs1, input int rs2,
                      input logic ordy, input logic clr);
    bit do_push, do_pop;
    @(negedge clk);
    check("in_ready",   32'(in_ready),   32'(m_q.size() < DEPTH));
    check("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
    check("out_code",   out_code,        (m_q.size() != 0) ? m_q[0] : 32'h0);
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
    in_valid  = v;
    in_op     = 4'(op);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    out_ready = ordy;
    clr_err   = clr;
    do_push = v && (m_q.size() < DEPTH);
    do_pop  = ordy && (m_q.size() != 0);
    if (do_pop) begin
      void'(m_q.pop_front());
      m_cnt = m_cnt + 1'b1;
    end
    if (do_push) begin
`ifdef RTYPE_ILLEGAL_DROP_EN
      if (op < 10) m_q.push_back(ref_code(op, rd, rs1, rs2));
`else
      m_q.push_back(ref_code(op, rd, rs1, rs2));
`endif
    end
    if (do_push && op >= 10) m_ill = 1'b1;
    else if (clr)            m_ill = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 0, 0, 0, 0, ordy, 1'b0);
  endtask

  // Assert reset between clock edges and check outputs before any edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_in_ready",   32'(in_ready),   32'h1);
    check("rst_illegal",    32'(illegal_op), 32'h0);
    check("rst_issued",     32'(issued_cnt), 32'h0);
    check("rst_out_code",   out_code,        32'h0);
    m_q.delete();
    m_ill = 1'b0;
    m_cnt = '0;
    in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_codes [4] = '{32'h40410033, 32'h02410033, 32'h00417033, 32'h00416033};

  initial begin
    do_reset();

    // Single ADD, visible one cycle after push, then popped
    step(1'b1, 0, 0, 2, 4, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("add_code", out_code, 32'h00410033);
    idle(1'b1);
    @(posedge clk); #1;
    check("add_issued", 32'(issued_cnt), 32'd1);

    // SUB/MUL/AND/OR in order
    for (int i = 1; i <= 4; i++) step(1'b1, i, 0, 2, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("seq_code", out_code, exp_codes[i]);
      idle(i < 3);
    end
    idle(1'b1);

    // Fill while stalled, then offer a push on the same cycle as a pop
    for (int i = 0; i < 5; i++) step(1'b1, i, i + 1, i + 2, i + 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    step(1'b1, 9, 31, 30, 29, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Full-rate streaming
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, i % 10, i, 31 - i, i + 7, 1'b1, 1'b0);
    idle(1'b1);
    @(posedge clk); #1;
    check("stream_issued", 32'(issued_cnt), 32'd12);

    // Illegal op handling, set beats clear
    step(1'b1, 12, 3, 4, 5, 1'b0, 1'b0);
    step(1'b1, 13, 1, 1, 1, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));

    // Reset with words buffered
    for (int i = 0; i < 3; i++) step(1'b1, i, i, i, i, 1'b0, 1'b0);
    idle(1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
